// File: rtl/calc_pkg.sv
// Shared key-code encodings, ALU op codes and controller states for the keypad calculator.
package calc_pkg;

  localparam logic [1:0] KEY_OP_PREFIX = 2'b10;
  localparam logic [4:0] KEY_ADD = 5'b10_000;
  localparam logic [4:0] KEY_SUB = 5'b10_001;
  localparam logic [4:0] KEY_MUL = 5'b10_010;
  localparam logic [4:0] KEY_DIV = 5'b10_011;
  localparam logic [4:0] KEY_EQ  = 5'b10_100;
  localparam logic [4:0] KEY_AC  = 5'b10_101;
  localparam logic [4:0] KEY_NEG = 5'b10_110;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    S_A,
    S_OP,
    S_B,
    S_REQ,
    S_WAIT,
    S_RES
  } ctrl_state_e;

endpackage

// File: rtl/operand_accumulator.sv
// Sign/magnitude decimal entry register with overflow-guarded x10+d accumulation.
module operand_accumulator #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             accum_i,
  input  logic             load_digit_i,
  input  logic [3:0]       digit_i,
  input  logic             toggle_sign_i,
  input  logic             load_value_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] value_o
);

  localparam int unsigned EXT = WIDTH + 4;
  localparam logic [EXT-1:0] MAX_POS = {5'b0, {(WIDTH-1){1'b1}}};

  logic             sign_q, sign_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [EXT-1:0]   acc_ext;

  assign acc_ext = ({4'b0, mag_q} * EXT'(10)) + EXT'(digit_i);

  // Later controls override earlier ones, so clear+load_digit yields a fresh +d.
  always_comb begin
    sign_d = sign_q;
    mag_d  = mag_q;
    if (clear_i) begin
      sign_d = 1'b0;
      mag_d  = '0;
    end
    if (load_digit_i) mag_d = WIDTH'(digit_i);
    if (accum_i && (acc_ext <= MAX_POS)) mag_d = acc_ext[WIDTH-1:0];
    if (toggle_sign_i) sign_d = ~sign_d;
    if (load_value_i) begin
      sign_d = value_i[WIDTH-1];
      mag_d  = value_i[WIDTH-1] ? -value_i : value_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
    end else begin
      sign_q <= sign_d;
      mag_q  <= mag_d;
    end
  end

  assign value_o = sign_q ? -mag_q : mag_q;

endmodule

// File: rtl/keypad_input_controller.sv
// Assembles operands and ops from keypad codes, issues ALU requests and chains results.
module keypad_input_controller
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_key,
  input  logic             i_key_valid,
  output logic             o_key_ready,
  output logic [WIDTH-1:0] o_operand_a,
  output logic [WIDTH-1:0] o_operand_b,
  output logic [1:0]       o_op,
  output logic             o_req_valid,
  input  logic             i_req_ready,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_result_valid,
  output logic [WIDTH-1:0] o_disp_value
);

  ctrl_state_e state_q, state_d;
  alu_op_e     op_q, op_d, pend_q, pend_d;
  logic        chain_q, chain_d;

  logic key_acc, is_digit, is_op, is_arith, is_eq, is_ac, is_neg;
  alu_op_e key_op;

  logic a_clear, a_accum, a_load_digit, a_toggle, a_load;
  logic b_clear, b_accum, b_load_digit, b_toggle;
  logic [WIDTH-1:0] a_val, b_val;

  assign key_acc  = i_key_valid && o_key_ready;
  assign is_digit = key_acc && !i_key[4] && (i_key[3:0] <= 4'd9);
  assign is_op    = key_acc && (i_key[4:3] == KEY_OP_PREFIX);
  assign is_arith = is_op && !i_key[2];
  assign is_eq    = is_op && (i_key == KEY_EQ);
  assign is_ac    = is_op && (i_key == KEY_AC);
  assign is_neg   = is_op && (i_key == KEY_NEG);
  assign key_op   = alu_op_e'(i_key[1:0]);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    pend_d       = pend_q;
    chain_d      = chain_q;
    a_clear      = 1'b0;
    a_accum      = 1'b0;
    a_load_digit = 1'b0;
    a_toggle     = 1'b0;
    a_load       = 1'b0;
    b_clear      = 1'b0;
    b_accum      = 1'b0;
    b_load_digit = 1'b0;
    b_toggle     = 1'b0;
    case (state_q)
      S_A: begin
        a_accum  = is_digit;
        a_toggle = is_neg;
        if (is_arith) begin
          op_d    = key_op;
          state_d = S_OP;
        end
      end
      S_OP: begin
        b_toggle = is_neg;
        if (is_digit) begin
          b_load_digit = 1'b1;
          state_d      = S_B;
        end
        if (is_arith) op_d = key_op;
      end
      S_B: begin
        b_accum  = is_digit;
        b_toggle = is_neg;
        if (is_eq) begin
          chain_d = 1'b0;
          state_d = S_REQ;
        end
        if (is_arith) begin
          pend_d  = key_op;
          chain_d = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (i_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_result_valid) begin
          a_load  = 1'b1;
          b_clear = 1'b1;
          if (chain_q) begin
            op_d    = pend_q;
            state_d = S_OP;
          end else begin
            state_d = S_RES;
          end
        end
      end
      S_RES: begin
        a_toggle = is_neg;
        if (is_digit) begin
          a_clear      = 1'b1;
          a_load_digit = 1'b1;
          state_d      = S_A;
        end
        if (is_arith) begin
          op_d    = key_op;
          state_d = S_OP;
        end
      end
      default: state_d = S_A;
    endcase
    if (is_ac) begin
      a_clear = 1'b1;
      b_clear = 1'b1;
      op_d    = OP_ADD;
      pend_d  = OP_ADD;
      chain_d = 1'b0;
      state_d = S_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      op_q    <= OP_ADD;
      pend_q  <= OP_ADD;
      chain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      chain_q <= chain_d;
    end
  end

  operand_accumulator #(.WIDTH(WIDTH)) u_acc_a (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (a_clear),
    .accum_i       (a_accum),
    .load_digit_i  (a_load_digit),
    .digit_i       (i_key[3:0]),
    .toggle_sign_i (a_toggle),
    .load_value_i  (a_load),
    .value_i       (i_result),
    .value_o       (a_val)
  );

  operand_accumulator #(.WIDTH(WIDTH)) u_acc_b (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (b_clear),
    .accum_i       (b_accum),
    .load_digit_i  (b_load_digit),
    .digit_i       (i_key[3:0]),
    .toggle_sign_i (b_toggle),
    .load_value_i  (1'b0),
    .value_i       ('0),
    .value_o       (b_val)
  );

  assign o_key_ready  = (state_q != S_REQ) && (state_q != S_WAIT);
  assign o_req_valid  = (state_q == S_REQ);
  assign o_op         = op_q;
  assign o_operand_a  = a_val;
  assign o_operand_b  = b_val;
  assign o_disp_value = ((state_q == S_A) || (state_q == S_OP) || (state_q == S_RES)) ? a_val : b_val;

endmodule

// File: tb/tb_keypad_input_controller.sv
// Table-driven and scoreboard-checked bench for keypad_input_controller.
module tb_keypad_input_controller;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  i_key = '0;
  logic        i_key_valid = 1'b0;
  logic        o_key_ready;
  logic [15:0] o_operand_a, o_operand_b;
  logic [1:0]  o_op;
  logic        o_req_valid;
  logic        i_req_ready = 1'b1;
  logic [15:0] i_result = '0;
  logic        i_result_valid = 1'b0;
  logic [15:0] o_disp_value;

  keypad_input_controller #(.WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_key          (i_key),
    .i_key_valid    (i_key_valid),
    .o_key_ready    (o_key_ready),
    .o_operand_a    (o_operand_a),
    .o_operand_b    (o_operand_b),
    .o_op           (o_op),
    .o_req_valid    (o_req_valid),
    .i_req_ready    (i_req_ready),
    .i_result       (i_result),
    .i_result_valid (i_result_valid),
    .o_disp_value   (o_disp_value)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } req_t;

  typedef struct {
    logic [0:7][4:0] keys;
    int unsigned     nkeys;
    req_t            exp_req;
    logic [15:0]     result;
    logic [15:0]     exp_disp;
  } vec_t;

  req_t q_exp[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check_req();
    req_t e;
    if (q_exp.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_req: got a=%h b=%h op=%0d expected none", o_operand_a, o_operand_b, o_op);
    end else begin
      e = q_exp.pop_front();
      check("req_a", o_operand_a, e.a);
      check("req_b", o_operand_b, e.b);
      check("req_op", 16'(o_op), 16'(e.op));
    end
  endtask

  task automatic send_key(input logic [4:0] k);
    int cnt = 0;
    i_key = k;
    i_key_valid = 1'b1;
    while (!o_key_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!o_key_ready) check("key_ready_timeout", 16'(o_key_ready), 16'd1);
    @(posedge clk); #1;
    i_key_valid = 1'b0;
  endtask

  // Walks through S_REQ into S_WAIT, scoring the request at its handshake cycle.
  task automatic wait_for_wait_state();
    int cnt = 0;
    bit done = 0;
    while (!done && cnt < 20) begin
      if (o_req_valid && i_req_ready) sb_check_req();
      if (!o_key_ready && !o_req_valid) done = 1;
      else begin
        @(posedge clk); #1;
        cnt++;
      end
    end
    if (!done) check("wait_state_timeout", 16'(done), 16'd1);
  endtask

  task automatic give_result(input logic [15:0] r);
    i_result = r;
    i_result_valid = 1'b1;
    @(posedge clk); #1;
    i_result_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"}, 16'(o_key_ready), 16'd1);
    check({tag, "_req_valid"}, 16'(o_req_valid), 16'd0);
    check({tag, "_operand_a"}, o_operand_a, 16'd0);
    check({tag, "_operand_b"}, o_operand_b, 16'd0);
    check({tag, "_op"}, 16'(o_op), 16'd0);
    check({tag, "_disp"}, o_disp_value, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{keys: {5'd1, 5'd2, KEY_ADD, 5'd3, 5'd4, KEY_EQ, 5'd0, 5'd0}, nkeys: 6,
                exp_req: '{a: 16'd12, b: 16'd34, op: 2'b00}, result: 16'd46, exp_disp: 16'd46};
    vecs[1] = '{keys: {5'd7, KEY_NEG, KEY_MUL, KEY_NEG, 5'd3, KEY_EQ, 5'd0, 5'd0}, nkeys: 6,
                exp_req: '{a: 16'hFFF9, b: 16'hFFFD, op: 2'b10}, result: 16'd21, exp_disp: 16'd21};
    vecs[2] = '{keys: {5'd9, KEY_SUB, 5'd5, 5'd0, KEY_EQ, 5'd0, 5'd0, 5'd0}, nkeys: 5,
                exp_req: '{a: 16'd9, b: 16'd50, op: 2'b01}, result: 16'hFFD7, exp_disp: 16'hFFD7};
    vecs[3] = '{keys: {5'd1, 5'd0, 5'd0, KEY_DIV, KEY_NEG, KEY_NEG, 5'd4, KEY_EQ}, nkeys: 8,
                exp_req: '{a: 16'd100, b: 16'd4, op: 2'b11}, result: 16'd25, exp_disp: 16'd25};
    vecs[4] = '{keys: {5'd3, 5'd2, 5'd7, 5'd6, 5'd7, 5'd9, KEY_ADD, 5'd1}, nkeys: 8,
                exp_req: '{a: 16'h7FFF, b: 16'd1, op: 2'b00}, result: 16'h8000, exp_disp: 16'h8000};
    vecs[5] = '{keys: {5'd4, 5'h0A, 5'h18, KEY_ADD, 5'd6, 5'h1F, KEY_EQ, 5'd0}, nkeys: 7,
                exp_req: '{a: 16'd4, b: 16'd6, op: 2'b00}, result: 16'd10, exp_disp: 16'd10};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("after_reset");

    for (int v = 0; v < 6; v++) begin
      send_key(KEY_AC);
      check("ac_disp", o_disp_value, 16'd0);
      for (int unsigned k = 0; k < vecs[v].nkeys; k++) send_key(vecs[v].keys[k]);
      if (v == 4) begin
        check("overflow_disp_b", o_disp_value, 16'd1);
        send_key(KEY_EQ);
      end
      q_exp.push_back(vecs[v].exp_req);
      wait_for_wait_state();
      give_result(vecs[v].result);
      check("res_disp", o_disp_value, vecs[v].exp_disp);
      check("res_key_ready", 16'(o_key_ready), 16'd1);
      check("sb_empty", 16'(q_exp.size()), 16'd0);
    end

    // Chained operation: the second op key launches the first request.
    send_key(KEY_AC);
    send_key(5'd5); send_key(KEY_ADD); send_key(5'd2);
    q_exp.push_back('{a: 16'd5, b: 16'd2, op: 2'b00});
    send_key(KEY_SUB);
    wait_for_wait_state();
    give_result(16'd7);
    check("chain_op", 16'(o_op), 16'd1);
    check("chain_disp", o_disp_value, 16'd7);
    check("chain_b_cleared", o_operand_b, 16'd0);
    check("chain_key_ready", 16'(o_key_ready), 16'd1);
    send_key(5'd1);
    q_exp.push_back('{a: 16'd7, b: 16'd1, op: 2'b01});
    send_key(KEY_EQ);
    wait_for_wait_state();
    give_result(16'd6);
    check("chain2_disp", o_disp_value, 16'd6);

    // ALU backpressure with a key held by the scanner.
    send_key(KEY_AC);
    i_req_ready = 1'b0;
    send_key(5'd8); send_key(KEY_MUL); send_key(5'd2);
    q_exp.push_back('{a: 16'd8, b: 16'd2, op: 2'b10});
    send_key(KEY_EQ);
    i_key = 5'd3;
    i_key_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_req_valid", 16'(o_req_valid), 16'd1);
      check("bp_key_ready", 16'(o_key_ready), 16'd0);
      check("bp_operand_a", o_operand_a, 16'd8);
      @(posedge clk); #1;
    end
    i_req_ready = 1'b1;
    if (o_req_valid) sb_check_req();
    @(posedge clk); #1;
    check("bp_req_fell", 16'(o_req_valid), 16'd0);
    check("bp_wait_key_ready", 16'(o_key_ready), 16'd0);
    give_result(16'd16);
    check("bp_res_disp", o_disp_value, 16'd16);
    @(posedge clk); #1;
    i_key_valid = 1'b0;
    check("bp_held_key_disp", o_disp_value, 16'd3);
    check("bp_held_key_a", o_operand_a, 16'd3);
    check("bp_sb_empty", 16'(q_exp.size()), 16'd0);

    // AC in the middle of B entry.
    send_key(KEY_AC);
    send_key(5'd4); send_key(KEY_ADD); send_key(5'd5);
    check("sb_disp_b", o_disp_value, 16'd5);
    send_key(KEY_AC);
    check_reset_outputs("ac_in_b");
    send_key(5'd2);
    check("ac_then_digit_a", o_operand_a, 16'd2);
    check("ac_then_digit_b", o_operand_b, 16'd0);

    // Asynchronous reset while waiting on the ALU.
    send_key(KEY_AC);
    send_key(5'd6); send_key(KEY_ADD); send_key(5'd1);
    q_exp.push_back('{a: 16'd6, b: 16'd1, op: 2'b00});
    send_key(KEY_EQ);
    wait_for_wait_state();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    give_result(16'd99);
    check("post_rst_result_ignored", o_disp_value, 16'd0);
    check("post_rst_req_valid", 16'(o_req_valid), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_input_controller.md
# keypad_input_controller

Consumes the 5-bit key-code stream from the keypad scanner via a valid/ready handshake and assembles signed decimal operands and a pending operation. It issues compute requests to the ALU and loads returned results back as the next operand, which allows chained arithmetic. It also drives the value to be shown by the display path.

## Interface
- WIDTH, 16, operand/result width in two's complement (≥ 8)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_key  in  5  key code: 0_dddd matrix key (0–9 digit, 10–15 unused); 10_ooo op (000 +, 001 −, 010 ×, 011 ÷, 100 =, 101 AC, 110 NEG); other codes unused
- i_key_valid  in  1  key code valid
- o_key_ready  out  1  controller accepts key
- o_operand_a  out  WIDTH  request operand A, two's complement
- o_operand_b  out  WIDTH  request operand B, two's complement
- o_op  out  2  request op (00 +, 01 −, 10 ×, 11 ÷)
- o_req_valid  out  1  ALU request valid
- i_req_ready  in  1  ALU accepts request
- i_result  in  WIDTH  ALU result, two's complement
- i_result_valid  in  1  result strobe, one cycle
- o_disp_value  out  WIDTH  value to display, two's complement

## Operation
- **Key acceptance:** a key is accepted when i_key_valid && o_key_ready. Unused codes are accepted and ignored.
- **o_key_ready:** 1 in S_A, S_OP, S_B, S_RES; 0 in S_REQ, S_WAIT.
- **Operand storage:** A and B are each held as a sign bit plus a WIDTH-bit magnitude.
- **Digit d:** mag ← mag·10 + d, computed in WIDTH+4 bits. The digit is ignored if the result exceeds 2^(WIDTH−1)−1.
- **NEG:** toggles the sign of the current entry operand. −0 displays and outputs as 0.
- **S_A** (reset state)
  - digit → accumulate into A
  - NEG → toggle A sign
  - +−×÷ → op ← code, go to S_OP
  - = → no effect
- **S_OP**
  - digit → B ← d (sign kept), go to S_B
  - NEG → toggle B sign
  - +−×÷ → replace op
  - = → no effect
- **S_B**
  - digit → accumulate into B
  - NEG → toggle B sign
  - = → chain ← 0, go to S_REQ
  - +−×÷ → pending_op ← code, chain ← 1, go to S_REQ
- **S_REQ:** o_req_valid = 1, operands/op stable. On i_req_ready → S_WAIT.
- **S_WAIT:** on i_result_valid:
  - A ← i_result split into sign/magnitude; −2^(WIDTH−1) becomes magnitude 2^(WIDTH−1).
  - B ← 0.
  - If chain: op ← pending_op, go to S_OP; else go to S_RES.
- **S_RES**
  - digit → A ← +d, go to S_A
  - NEG → toggle A sign
  - +−×÷ → op ← code, go to S_OP
  - = → no effect
- **AC** (accepted states): A, B, signs, op, chain ← 0; go to S_A.
- **Display:** o_disp_value = A in S_A, S_OP, S_RES; B in S_B, S_REQ, S_WAIT.

## Timing
- **Reset values:** o_key_ready 1; o_req_valid 0; o_operand_a, o_operand_b, o_disp_value 0; o_op 00. State S_A, internal registers 0.
- **Key latency:** an accepted key's effect is visible on outputs the next cycle. One key per cycle is accepted back-to-back.
- **o_req_valid:** registered; rises the cycle after the accepted = or op. It holds with stable operands until the i_req_ready cycle and falls the next cycle.
- **i_result_valid:** ignored outside S_WAIT. A result in the same cycle as the entry into S_WAIT is not possible, because the transition is registered.
- **i_key_valid:** a key presented while o_key_ready = 0 is not consumed; the scanner holds it.
- **Mid-operation reset:** asynchronous reset returns everything to reset values immediately. No request survives it.

## Structure
- calc_pkg holds:
  - key-code localparams (KEY_ADD … KEY_NEG, op prefix 2'b10)
  - alu_op_e enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
  - ctrl_state_e enum (S_A, S_OP, S_B, S_REQ, S_WAIT, S_RES)
- Sub-module operand_accumulator (parameter WIDTH) is instantiated twice, for A and B:
  - inputs: clear, load_digit, digit, toggle_sign, load_value, value
  - behaviour: overflow-guarded ×10+d
  - output: two's-complement value

## Test plan
- 1, 2, +, 3, 4, = with i_req_ready = 1 → request A=12, B=34, op=00. Feed i_result=46 → S_RES, o_disp_value=46.
- 7, NEG, ×, NEG, 3, = → A=−7 (0xFFF9), B=−3 (0xFFFD), op=10.
- WIDTH=16: digits 3,2,7,6,7,9 → A=32767; the final 9 is ignored.
- 5, +, 2, − with i_result=7 → next state S_OP, op=01. Then 1, = → request A=7, B=1, op=01.
- i_req_ready held 0 for 5 cycles with i_key_valid asserted → o_req_valid held, o_key_ready 0, key not consumed.
- In S_B, press AC → all zero, S_A. Assert rst_n=0 mid-S_WAIT → outputs return to reset values the same cycle.
